// File: rtl/vga_timing_receiver.sv
// Video sink: registers an RGB/de/sync stream, recovers pixel coordinates and
// frame markers, measures active geometry and tracks lock against the expected size.
module vga_timing_receiver #(
  parameter int unsigned H_ACTIVE = 1280,
  parameter int unsigned V_ACTIVE = 720,
  parameter bit          VS_POL   = 1'b1,
  parameter int unsigned CW       = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    r,
  input  logic [7:0]    g,
  input  logic [7:0]    b,
  input  logic          de,
  input  logic          vsync,
  input  logic          hsync,
  output logic [7:0]    pix_r,
  output logic [7:0]    pix_g,
  output logic [7:0]    pix_b,
  output logic          pix_valid,
  output logic          pix_hsync,
  output logic          pix_vsync,
  output logic [CW-1:0] pix_x,
  output logic [CW-1:0] pix_y,
  output logic          sof,
  output logic          eol,
  output logic [CW-1:0] meas_width,
  output logic [CW-1:0] meas_height,
  output logic          locked,
  output logic          err
);

  localparam int unsigned GW = 2;
  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0] H_EXP   = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_EXP   = CW'(V_ACTIVE);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    CHECK  = 2'd1,
    LOCK   = 2'd2
  } state_t;

  // Stage A: raw input capture
  logic [7:0] a_r, a_g, a_b;
  logic       a_de, a_vs, a_hs;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r  <= '0;
      a_g  <= '0;
      a_b  <= '0;
      a_de <= 1'b0;
      a_vs <= 1'b0;
      a_hs <= 1'b0;
    end else begin
      a_r  <= r;
      a_g  <= g;
      a_b  <= b;
      a_de <= de;
      a_vs <= vsync;
      a_hs <= hsync;
    end
  end

  logic [CW-1:0] x, y;
  logic [CW-1:0] x_inc, y_inc, lines_c;
  logic          vs_start, line_end, width_bad, frame_good;
  logic          frame_ok, sof_armed, sof_hit;

  assign vs_start  = (vsync == VS_POL) && (a_vs != VS_POL);
  assign line_end  = a_de && !de;
  assign x_inc     = (x == CNT_MAX) ? x : x + CW'(1);
  assign y_inc     = (y == CNT_MAX) ? y : y + CW'(1);
  assign width_bad = line_end && (x_inc != H_EXP);
  // A line ending together with vs_start still belongs to the closing frame
  assign lines_c    = line_end ? y_inc : y;
  assign frame_good = frame_ok && !width_bad && (lines_c == V_EXP);
  assign sof_hit    = sof_armed && a_de && (x == '0) && (y == '0);

  // Coordinate counters and geometry measurement
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x           <= '0;
      y           <= '0;
      meas_width  <= '0;
      meas_height <= '0;
      frame_ok    <= 1'b0;
      sof_armed   <= 1'b0;
    end else begin
      if (line_end)  x <= '0;
      else if (a_de) x <= x_inc;

      if (vs_start)      y <= '0;
      else if (line_end) y <= y_inc;

      if (line_end) meas_width  <= x_inc;
      if (vs_start) meas_height <= lines_c;

      if (vs_start)       frame_ok <= 1'b1;
      else if (width_bad) frame_ok <= 1'b0;

      if (vs_start)     sof_armed <= 1'b1;
      else if (sof_hit) sof_armed <= 1'b0;
    end
  end

  // Stage B: output pixel with coordinates and markers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_r     <= '0;
      pix_g     <= '0;
      pix_b     <= '0;
      pix_valid <= 1'b0;
      pix_hsync <= 1'b0;
      pix_vsync <= 1'b0;
      pix_x     <= '0;
      pix_y     <= '0;
      sof       <= 1'b0;
      eol       <= 1'b0;
    end else begin
      pix_r     <= a_r;
      pix_g     <= a_g;
      pix_b     <= a_b;
      pix_valid <= a_de;
      pix_hsync <= a_hs;
      pix_vsync <= a_vs;
      pix_x     <= a_de ? x : '0;
      pix_y     <= a_de ? y : '0;
      sof       <= sof_hit;
      eol       <= line_end;
    end
  end

  state_t        state, state_next;
  logic [GW-1:0] good_cnt, good_cnt_next;
  logic          locked_next, err_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= SEARCH;
      good_cnt <= '0;
      locked   <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_next;
      good_cnt <= good_cnt_next;
      locked   <= locked_next;
      err      <= err_next;
    end
  end

  // Lock tracking: two consecutive good frames to lock, any bad frame drops it
  always_comb begin
    state_next    = state;
    good_cnt_next = good_cnt;
    locked_next   = locked;
    err_next      = 1'b0;
    case (state)
      SEARCH: begin
        locked_next = 1'b0;
        if (vs_start) begin
          state_next    = CHECK;
          good_cnt_next = '0;
        end
      end
      CHECK: begin
        locked_next = 1'b0;
        if (vs_start) begin
          if (!frame_good) begin
            good_cnt_next = '0;
          end else if (good_cnt == GW'(1)) begin
            good_cnt_next = GW'(2);
            state_next    = LOCK;
            locked_next   = 1'b1;
          end else begin
            good_cnt_next = good_cnt + GW'(1);
          end
        end
      end
      LOCK: begin
        if (width_bad) err_next = 1'b1;
        if (vs_start && !frame_good) begin
          err_next      = 1'b1;
          locked_next   = 1'b0;
          state_next    = CHECK;
          good_cnt_next = '0;
        end
      end
      default: begin
        state_next    = SEARCH;
        good_cnt_next = '0;
        locked_next   = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_vga_timing_receiver.sv
// Directed bench for vga_timing_receiver on a reduced 8x4 geometry.
module tb_vga_timing_receiver;

  localparam int unsigned H  = 8;
  localparam int unsigned V  = 4;
  localparam int unsigned CW = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    r, g, b;
  logic          de, vsync, hsync;
  logic [7:0]    pix_r, pix_g, pix_b;
  logic          pix_valid, pix_hsync, pix_vsync;
  logic [CW-1:0] pix_x, pix_y;
  logic          sof, eol;
  logic [CW-1:0] meas_width, meas_height;
  logic          locked, err;

  int total = 0;
  int bad   = 0;

  int err_cnt    = 0;
  int sof_cnt    = 0;
  int last_x     = -1;
  int last_y     = -1;
  int last_eol_x = -1;
  int e0;

  vga_timing_receiver #(
    .H_ACTIVE(H), .V_ACTIVE(V), .VS_POL(1'b1), .CW(CW)
  ) dut (
    .clk(clk), .rst(rst), .r(r), .g(g), .b(b), .de(de), .vsync(vsync), .hsync(hsync),
    .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b), .pix_valid(pix_valid),
    .pix_hsync(pix_hsync), .pix_vsync(pix_vsync), .pix_x(pix_x), .pix_y(pix_y),
    .sof(sof), .eol(eol), .meas_width(meas_width), .meas_height(meas_height),
    .locked(locked), .err(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (err) err_cnt++;
    if (sof) sof_cnt++;
    if (pix_valid) begin
      last_x = int'(pix_x);
      last_y = int'(pix_y);
    end
    if (eol) last_eol_x = int'(pix_x);
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int any_out();
    return int'(|{pix_r, pix_g, pix_b, pix_valid, pix_hsync, pix_vsync, pix_x, pix_y,
                  sof, eol, meas_width, meas_height, locked, err});
  endfunction

  task automatic send_line(input int w, input bit first, input bit vs_end);
    for (int i = 0; i < w; i++) begin
      de = 1'b1; hsync = 1'b0; vsync = 1'b0;
      r = 8'(i + 16); g = 8'(i + 32); b = 8'(i + 48);
      tick();
      if (first && i == 0) chk("lat_early_valid", int'(pix_valid), 0);
      if (first && i == 1) begin
        chk("first_valid", int'(pix_valid), 1);
        chk("first_x", int'(pix_x), 0);
        chk("first_y", int'(pix_y), 0);
        chk("first_sof", int'(sof), 1);
        chk("first_r", int'(pix_r), 16);
      end
    end
    for (int j = 0; j < 3; j++) begin
      de = 1'b0;
      hsync = (j == 1);
      vsync = vs_end && (j < 2);
      tick();
    end
    vsync = 1'b0;
  endtask

  task automatic send_frame(input int nlines, input bit first, input bit coinc);
    for (int l = 0; l < nlines; l++)
      send_line(H, first && (l == 0), coinc && (l == nlines - 1));
  endtask

  task automatic send_vsync(input int exp_before, input int exp_after);
    if (exp_before >= 0) chk("lock_before_vs", int'(locked), exp_before);
    vsync = 1'b1; de = 1'b0;
    tick();
    chk("lock_after_vs", int'(locked), exp_after);
    tick();
    vsync = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    rst = 1'b1; r = '0; g = '0; b = '0; de = 1'b0; vsync = 1'b0; hsync = 1'b0;
    tick(); tick();
    chk("reset_outputs", any_out(), 0);
    rst = 1'b0;
    tick();

    // Mid-line asynchronous reset
    send_line(H, 1'b0, 1'b0);
    chk("pre_width", int'(meas_width), 8);
    for (int i = 0; i < 3; i++) begin
      de = 1'b1; r = 8'hAA; tick();
    end
    chk("pre_rst_valid", int'(pix_valid), 1);
    #1 rst = 1'b1;
    #1 chk("midline_rst_outputs", any_out(), 0);
    #1 rst = 1'b0;
    de = 1'b0;
    tick(); tick();

    // Partial frame without vsync: no sof
    send_frame(2, 1'b0, 1'b0);
    chk("search_no_sof", sof_cnt, 0);
    chk("search_unlocked", int'(locked), 0);

    // Frame 1 with latency/coordinate checks
    send_vsync(0, 0);
    send_frame(V, 1'b1, 1'b0);
    chk("last_x", last_x, 7);
    chk("last_y", last_y, 3);
    chk("eol_x", last_eol_x, 7);
    chk("width", int'(meas_width), 8);
    chk("sof_once", sof_cnt, 1);
    send_vsync(0, 0);
    chk("height", int'(meas_height), 4);

    // Frame 2 then lock
    send_frame(V, 1'b0, 1'b0);
    send_vsync(0, 1);
    chk("no_err_lock", err_cnt, 0);
    chk("sof_per_frame", sof_cnt, 2);

    // Width error while locked
    e0 = err_cnt;
    send_line(H, 1'b0, 1'b0);
    send_line(H, 1'b0, 1'b0);
    send_line(H - 1, 1'b0, 1'b0);
    chk("short_width", int'(meas_width), 7);
    chk("short_err", err_cnt - e0, 1);
    chk("short_still_locked", int'(locked), 1);
    send_line(H, 1'b0, 1'b0);
    send_vsync(1, 0);
    chk("short_frame_errs", err_cnt - e0, 2);
    send_frame(V, 1'b0, 1'b0);
    send_vsync(0, 0);
    send_frame(V, 1'b0, 1'b0);
    send_vsync(0, 1);

    // Height error while locked
    e0 = err_cnt;
    send_frame(V - 1, 1'b0, 1'b0);
    send_vsync(1, 0);
    chk("short_height", int'(meas_height), 3);
    chk("height_err", err_cnt - e0, 1);

    // vsync coincident with last line's de fall
    e0 = err_cnt;
    send_frame(V, 1'b0, 1'b1);
    chk("coinc_height", int'(meas_height), 4);
    chk("coinc_unlocked", int'(locked), 0);
    send_frame(V, 1'b1, 1'b0);
    send_vsync(0, 1);
    chk("coinc_no_err", err_cnt - e0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_timing_receiver.md
Name: vga_timing_receiver

Overview:
- Sink-side counterpart of vga_generator.
- Consumes a parallel RGB + de/hsync/vsync video stream, for example 720p from the generator or a capture front-end.
- Recovers per-pixel coordinates, start-of-frame and end-of-line markers, and measures active geometry.
- Declares lock after two consecutive frames match the expected geometry, and feeds downstream pixel-processing stages of the plate-recognition pipeline.

Parameters:
- H_ACTIVE, 1280, expected active pixels per line (de-high cycles).
- V_ACTIVE, 720, expected active lines per frame.
- VS_POL, 1, vsync active level (1 = active-high, as in 720p).
- CW, 12, width of coordinate and measurement counters.

Ports:
- clk  in  1  pixel clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- r  in  8  red input.
- g  in  8  green input.
- b  in  8  blue input.
- de  in  1  data enable input.
- vsync  in  1  vertical sync input.
- hsync  in  1  horizontal sync input; passed through only, not used for timing.
- pix_r  out  8  registered red.
- pix_g  out  8  registered green.
- pix_b  out  8  registered blue.
- pix_valid  out  1  registered de.
- pix_hsync  out  1  delayed hsync.
- pix_vsync  out  1  delayed vsync.
- pix_x  out  CW  column index of the current valid pixel.
- pix_y  out  CW  row index of the current valid pixel.
- sof  out  1  high with pixel (0,0) of each frame.
- eol  out  1  high with the last valid pixel of each line.
- meas_width  out  CW  de-high count of the most recent completed line.
- meas_height  out  CW  line count of the most recent completed frame.
- locked  out  1  geometry locked.
- err  out  1  one-cycle geometry error pulse.

Behaviour:
- Reset (async): every output is 0. Internal counters are 0 and the FSM is in SEARCH.
- Pipeline
  - Stage A registers r, g, b, de, vsync and hsync.
  - Stage B drives all pix_* outputs, sof and eol.
  - Fixed latency is 2 clk from input to the pix_* outputs, including syncs.
- Edge detection
  - The vsync leading edge (vs_start) is a transition into the VS_POL level, detected between the raw input and stage A.
  - The de falling edge (line_end) is stage A de=1 while the raw de=0.
- Horizontal counter x
  - Increments on each stage A de=1 cycle.
  - pix_x carries the pre-increment value, so the first pixel of a line is 0.
  - Cleared on line_end.
  - Saturates at 2^CW-1.
- eol
  - Asserted at stage B for the pixel where line_end was detected, i.e. the last de=1 pixel of the line.
- Vertical counter y
  - Increments on line_end.
  - pix_y holds the value for the whole line.
  - Cleared on vs_start.
  - Saturates.
- sof
  - Asserted with the first valid pixel whose pix_x=0 and pix_y=0 after a vs_start.
  - At most one sof per vs_start.
- meas_width
  - Loaded with x+1 at line_end, i.e. the full line length.
- meas_height
  - Loaded with the y value at vs_start.
  - If line_end and vs_start fall in the same cycle, the line is counted first, so meas_height includes that line.
- Frame check
  - The frame_ok flag is set at vs_start.
  - It is cleared at any line_end whose width is not H_ACTIVE.
  - The frame is good at the next vs_start if frame_ok=1 and the line count equals V_ACTIVE.
- FSM
  - SEARCH: the partial frame before the first vsync is ignored. On vs_start, go to CHECK with good_cnt=0.
  - CHECK: at each vs_start, a good frame increments good_cnt; a bad frame resets it to 0. On the second consecutive good frame, go to LOCKED and set locked=1 in the same cycle as vs_start +1.
  - LOCKED, width mismatch: a line_end width mismatch gives an err pulse one cycle after line_end. The state stays LOCKED until the frame boundary.
  - LOCKED, bad frame: at vs_start a bad frame gives locked=0 and an err pulse. The state goes to CHECK with good_cnt=0.
  - Error rate: at most one err pulse per cycle.
- No activity
  - Counters are held.
  - locked stays at its last value. There is no timeout, since lock loss is detected at the next frame boundary.
- Mid-stream reset: all state is cleared immediately, and the block re-enters SEARCH.

Test Plan:
1. Reset: assert rst mid-line with de=1 -> all outputs 0 in the same cycle. After release, the FSM is in SEARCH and no sof appears until a vs_start.
2. Latency and coordinates: one 1280x720 frame after the first vsync -> the first pix_valid comes 2 clk after the input de rise with pix_x=0, pix_y=0 and sof=1. eol is high at pix_x=1279. The last pixel is (1279,719). meas_width=1280. meas_height=720 at the next vsync.
3. Lock acquisition: three consecutive 1280x720 frames -> locked=1 one cycle after the 3rd vs_start, i.e. after two good frames, with no err.
4. Width error while locked: line 300 has 1279 de cycles -> err pulses once after that line, meas_width=1279, locked stays 1 until vs_start, then locked=0 with a second err pulse. Two further good frames -> relock.
5. Height error: a frame of 719 lines while locked -> meas_height=719, locked=0, exactly one err pulse at vs_start.
6. Coincident edges: vsync rises in the same cycle the 720th line's de falls -> meas_height=720, the frame counts as good, and y clears to 0.
